input_debouncer: RTL and testbench

Synchronizing debouncer for the push-button/switch inputs on `ui_in`, sitting directly upstream of the `C_AND` gate stage. Each channel runs the raw pin through a 2-flop synchronizer and a per-channel stability state machine, then presents a clean level plus one-cycle rise and fall pulses. Channel 0 also drives an 8-bit press counter for display on `uo_out`. The top level connects `db_out[1:0]` to the AND gate inputs in place of raw `ui_in[1:0]`.

---
 rtl/input_debouncer.sv | 133 +++++++++++++
 tb/tb_input_debouncer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/input_debouncer.sv
// rtl/input_debouncer.sv - multi-channel synchronizing debouncer with edge pulses and press counter
//
// Purpose: each raw input goes through a 2-flop synchronizer and a four-state
// stability FSM. A new level is accepted only after DEBOUNCE_CYCLES consecutive
// matching synchronized samples. Accepted changes produce a one-cycle rise or fall
// pulse. Channel 0 rise pulses also advance a wrapping 8-bit counter.
//
// Ports:
//   clk        - single clock, rising edge
//   rst        - synchronous active-high reset
//   raw_in     - asynchronous raw pins, one per channel
//   db_out     - debounced level per channel
//   rise_pulse - one-cycle pulse when db_out goes 0->1
//   fall_pulse - one-cycle pulse when db_out goes 1->0
//   rise_count - wrapping count of channel 0 rise pulses
module input_debouncer #(
  parameter int CHANNELS        = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] raw_in,
  output logic [CHANNELS-1:0] db_out,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse,
  output logic [7:0]          rise_count
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE_LOW,
    WAIT_HIGH,
    IDLE_HIGH,
    WAIT_LOW
  } state_t;

  logic [CHANNELS-1:0] s1;
  logic [CHANNELS-1:0] s2;
  state_t              state      [CHANNELS];
  state_t              state_next [CHANNELS];
  logic [CNT_W-1:0]    cnt        [CHANNELS];
  logic [CNT_W-1:0]    cnt_next   [CHANNELS];
  logic [CHANNELS-1:0] db_next;
  logic [CHANNELS-1:0] rise_next;
  logic [CHANNELS-1:0] fall_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1         <= '0;
      s2         <= '0;
      db_out     <= '0;
      rise_pulse <= '0;
      fall_pulse <= '0;
      rise_count <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        state[i] <= IDLE_LOW;
        cnt[i]   <= '0;
      end
    end else begin
      s1         <= raw_in;
      s2         <= s1;
      db_out     <= db_next;
      rise_pulse <= rise_next;
      fall_pulse <= fall_next;
      // Counts the registered pulse, so the count lags the pulse by one edge.
      rise_count <= rise_count + 8'(rise_pulse[0]);
      for (int i = 0; i < CHANNELS; i++) begin
        state[i] <= state_next[i];
        cnt[i]   <= cnt_next[i];
      end
    end
  end

  // cnt holds the number of matching samples already seen in a WAIT state;
  // entering WAIT consumes the first one, so acceptance happens at CNT_LAST.
  always_comb begin
    db_next   = db_out;
    rise_next = '0;
    fall_next = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      state_next[i] = state[i];
      cnt_next[i]   = cnt[i];
      case (state[i])
        IDLE_LOW: begin
          if (s2[i]) begin
            state_next[i] = WAIT_HIGH;
            cnt_next[i]   = CNT_ONE;
          end
        end
        WAIT_HIGH: begin
          if (!s2[i]) begin
            state_next[i] = IDLE_LOW;
            cnt_next[i]   = '0;
          end else if (cnt[i] == CNT_LAST) begin
            state_next[i] = IDLE_HIGH;
            cnt_next[i]   = '0;
            db_next[i]    = 1'b1;
            rise_next[i]  = 1'b1;
          end else begin
            cnt_next[i] = cnt[i] + CNT_ONE;
          end
        end
        IDLE_HIGH: begin
          if (!s2[i]) begin
            state_next[i] = WAIT_LOW;
            cnt_next[i]   = CNT_ONE;
          end
        end
        WAIT_LOW: begin
          if (s2[i]) begin
            state_next[i] = IDLE_HIGH;
            cnt_next[i]   = '0;
          end else if (cnt[i] == CNT_LAST) begin
            state_next[i] = IDLE_LOW;
            cnt_next[i]   = '0;
            db_next[i]    = 1'b0;
            fall_next[i]  = 1'b1;
          end else begin
            cnt_next[i] = cnt[i] + CNT_ONE;
          end
        end
        default: begin
          state_next[i] = IDLE_LOW;
          cnt_next[i]   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_input_debouncer.sv
// tb/tb_input_debouncer.sv - scoreboard bench for input_debouncer
module tb_input_debouncer;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] raw_in;
  logic [1:0] db_out;
  logic [1:0] rise_pulse;
  logic [1:0] fall_pulse;
  logic [7:0] rise_count;

  input_debouncer #(.CHANNELS(2), .DEBOUNCE_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .raw_in     (raw_in),
    .db_out     (db_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .rise_count (rise_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         at;
    int         ch;
    bit         rise;
    logic [7:0] cnt;
  } ev_t;

  ev_t        exp_q [$];
  int         checks = 0;
  int         errors = 0;
  int         edge_cnt = 0;
  logic       rst_seen = 1'b0;
  logic [7:0] exp_count = 8'd0;

  always @(posedge clk) begin
    edge_cnt <= edge_cnt + 1;
    rst_seen <= rst;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Raw change made at this negedge is first sampled at edge_cnt+1; two
  // synchronizer edges plus four FSM samples put the pulse at edge_cnt+6.
  task automatic push_ev(input int ch, input bit rise);
    ev_t e;
    e.at   = edge_cnt + 6;
    e.ch   = ch;
    e.rise = rise;
    if (ch == 0 && rise) exp_count = exp_count + 8'd1;
    e.cnt  = exp_count;
    exp_q.push_back(e);
  endtask

  logic [7:0] cnt_ref = 8'd0;
  logic [7:0] cnt_pend_val = 8'd0;
  bit         cnt_pending = 1'b0;
  ev_t        mon_e;
  logic       mon_hit;

  always @(negedge clk) begin
    if (rst_seen) begin
      check("reset_db_out", 32'(db_out), 32'd0);
      check("reset_rise_pulse", 32'(rise_pulse), 32'd0);
      check("reset_fall_pulse", 32'(fall_pulse), 32'd0);
      check("reset_rise_count", 32'(rise_count), 32'd0);
      cnt_ref     = 8'd0;
      cnt_pending = 1'b0;
    end else begin
      if (cnt_pending) begin
        cnt_ref     = cnt_pend_val;
        cnt_pending = 1'b0;
        check("rise_count_update", 32'(rise_count), 32'(cnt_ref));
      end
      for (int ch = 0; ch < 2; ch++) begin
        for (int k = 0; k < 2; k++) begin
          mon_hit = (k == 0) ? rise_pulse[ch] : fall_pulse[ch];
          if (mon_hit === 1'b1) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_pulse: ch %0d rise %0d at edge %0d, expected no pulse",
                       ch, (k == 0), edge_cnt);
            end else begin
              mon_e = exp_q.pop_front();
              check("pulse_edge", 32'(edge_cnt), 32'(mon_e.at));
              check("pulse_channel", 32'(ch), 32'(mon_e.ch));
              check("pulse_kind_rise", 32'(k == 0), 32'(mon_e.rise));
              check("db_out_level", 32'(db_out[ch]), 32'(mon_e.rise));
              check("rise_count_hold", 32'(rise_count), 32'(cnt_ref));
              if (mon_e.ch == 0 && mon_e.rise) begin
                cnt_pending  = 1'b1;
                cnt_pend_val = mon_e.cnt;
              end
            end
          end
        end
      end
    end
  end

  int pat [9] = '{1, 0, 1, 1, 0, 1, 1, 1, 1};

  initial begin
    raw_in    = 2'b11;
    rst       = 1'b1;
    exp_count = 8'd0;
    step(3);

    // Inputs held high across reset rise as a fresh event after release.
    rst = 1'b0;
    push_ev(0, 1'b1);
    push_ev(1, 1'b1);
    step(12);
    raw_in = 2'b00;
    push_ev(0, 1'b0);
    push_ev(1, 1'b0);
    step(12);

    // Clean press and release on channel 0.
    raw_in[0] = 1'b1;
    push_ev(0, 1'b1);
    step(8);
    raw_in[0] = 1'b0;
    push_ev(0, 1'b0);
    step(12);

    // Channel 1: three-sample high is rejected, four-sample high is accepted.
    raw_in[1] = 1'b1;
    step(3);
    raw_in[1] = 1'b0;
    step(12);
    raw_in[1] = 1'b1;
    push_ev(1, 1'b1);
    step(4);
    raw_in[1] = 1'b0;
    push_ev(1, 1'b0);
    step(12);

    // Bounce then settle on channel 0; only the final run is accepted.
    for (int i = 0; i < 9; i++) begin
      raw_in[0] = pat[i][0];
      if (i == 5) push_ev(0, 1'b1);
      step(1);
    end
    step(10);
    raw_in[0] = 1'b0;
    push_ev(0, 1'b0);
    step(12);

    // Simultaneous transitions on both channels.
    raw_in = 2'b11;
    push_ev(0, 1'b1);
    push_ev(1, 1'b1);
    step(8);
    raw_in = 2'b00;
    push_ev(0, 1'b0);
    push_ev(1, 1'b0);
    step(12);

    // Channel 1 presses leave rise_count untouched.
    for (int i = 0; i < 3; i++) begin
      raw_in[1] = 1'b1;
      push_ev(1, 1'b1);
      step(6);
      raw_in[1] = 1'b0;
      push_ev(1, 1'b0);
      step(6);
    end
    step(6);

    // Reset while channel 0 sits in WAIT_HIGH with cnt=2.
    raw_in[0] = 1'b1;
    step(4);
    rst       = 1'b1;
    exp_count = 8'd0;
    step(1);
    rst = 1'b0;
    push_ev(0, 1'b1);
    step(10);
    raw_in[0] = 1'b0;
    push_ev(0, 1'b0);
    step(12);

    // 256 presses from a fresh reset bring rise_count back to 0.
    rst       = 1'b1;
    exp_count = 8'd0;
    step(2);
    rst = 1'b0;
    step(4);
    for (int i = 0; i < 256; i++) begin
      raw_in[0] = 1'b1;
      push_ev(0, 1'b1);
      step(6);
      raw_in[0] = 1'b0;
      push_ev(0, 1'b0);
      step(6);
    end
    step(20);
    check("rise_count_wrapped", 32'(rise_count), 32'd0);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
